fastram_dram_scheduler: RTL and testbench

- Clocked DRAM sequencer and arbiter for the 8MB Zorro II FastRAM array (four RAS banks, shared UCAS/LCAS and WE).
- Arbitrates CPU accesses against CAS-before-RAS refresh. Keeps a refresh debt counter so refresh can defer behind bus traffic without ever starving the array.
- Sits between the address decode/autoconfig match logic and the DRAM pins. Provides the row/column mux select and the DTACK-enable strobe.

---
 rtl/fastram_dram_scheduler.sv | 144 ++++++++++++++
 tb/tb_fastram_dram_scheduler.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fastram_dram_scheduler.sv
// DRAM sequencer/arbiter for the Zorro II FastRAM array: CPU accesses vs CBR refresh.
// A refresh debt counter lets refresh defer behind bus traffic up to MAX_PENDING.
module fastram_dram_scheduler #(
  parameter int REFRESH_INTERVAL = 108,
  parameter int MAX_PENDING      = 4,
  parameter int RF_RAS_CYCLES    = 2
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       req,
  input  logic [1:0] bank,
  input  logic       rw_n,
  input  logic       uds_n,
  input  logic       lds_n,
  output logic [3:0] ras_n,
  output logic       ucas_n,
  output logic       lcas_n,
  output logic       mem_we_n,
  output logic       col_sel,
  output logic       ack,
  output logic       refresh_busy,
  output logic [2:0] pending,
  output logic       overrun
);

  localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int CW = $clog2(RF_RAS_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(REFRESH_INTERVAL - 1);
  localparam logic [2:0]    MAXP     = 3'(MAX_PENDING);

  typedef enum logic [2:0] {
    IDLE, ACC_ROW, ACC_COL, ACC_CAS, RF_CAS, RF_RAS, PRE
  } state_t;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [CW-1:0] rf_cnt_q;
  logic [2:0]    pending_q, pending_d;
  logic          overrun_q, overrun_d;
  logic [3:0]    ras_n_q;
  logic          ucas_n_q, lcas_n_q, mem_we_n_q, col_sel_q, ack_q, rf_busy_q;
  logic          tick, rf_dec, go_pre;

  assign tick   = (timer_q == TMR_LAST);
  // Debt is paid on the RF_CAS -> RF_RAS edge, which is unconditional.
  assign rf_dec = (state_q == RF_CAS);
  assign go_pre = ((state_q == ACC_ROW || state_q == ACC_COL || state_q == ACC_CAS) && !req) ||
                  (state_q == RF_RAS && rf_cnt_q == '0);

  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q | (tick && pending_q == 3'd7);
    if (tick && !rf_dec && pending_q != 3'd7)
      pending_d = pending_q + 3'd1;
    else if (rf_dec && !tick && pending_q != 3'd0)
      pending_d = pending_q - 3'd1;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      timer_q   <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= tick ? '0 : timer_q + 1'b1;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q    <= IDLE;
      rf_cnt_q   <= '0;
      ras_n_q    <= 4'hF;
      ucas_n_q   <= 1'b1;
      lcas_n_q   <= 1'b1;
      mem_we_n_q <= 1'b1;
      col_sel_q  <= 1'b0;
      ack_q      <= 1'b0;
      rf_busy_q  <= 1'b0;
    end else if (go_pre) begin
      state_q    <= PRE;
      ras_n_q    <= 4'hF;
      ucas_n_q   <= 1'b1;
      lcas_n_q   <= 1'b1;
      mem_we_n_q <= 1'b1;
      col_sel_q  <= 1'b0;
      ack_q      <= 1'b0;
      rf_busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // Saturated debt outranks the CPU; otherwise refresh only fills idle slots.
          if (pending_q >= MAXP || (!req && pending_q != 3'd0)) begin
            state_q    <= RF_CAS;
            ucas_n_q   <= 1'b0;
            lcas_n_q   <= 1'b0;
            mem_we_n_q <= 1'b1;
            rf_busy_q  <= 1'b1;
          end else if (req) begin
            state_q    <= ACC_ROW;
            ras_n_q    <= ~(4'b0001 << bank);
            mem_we_n_q <= rw_n;
            col_sel_q  <= 1'b0;
          end
        end
        ACC_ROW: begin
          state_q   <= ACC_COL;
          col_sel_q <= 1'b1;
        end
        ACC_COL: begin
          state_q  <= ACC_CAS;
          ack_q    <= 1'b1;
          ucas_n_q <= uds_n;
          lcas_n_q <= lds_n;
        end
        ACC_CAS: begin
          ucas_n_q <= uds_n;
          lcas_n_q <= lds_n;
        end
        RF_CAS: begin
          state_q  <= RF_RAS;
          ras_n_q  <= 4'h0;
          rf_cnt_q <= CW'(RF_RAS_CYCLES - 1);
        end
        RF_RAS:  rf_cnt_q <= rf_cnt_q - 1'b1;
        PRE:     state_q  <= IDLE;
        default: state_q  <= IDLE;
      endcase
    end
  end

  assign ras_n        = ras_n_q;
  assign ucas_n       = ucas_n_q;
  assign lcas_n       = lcas_n_q;
  assign mem_we_n     = mem_we_n_q;
  assign col_sel      = col_sel_q;
  assign ack          = ack_q;
  assign refresh_busy = rf_busy_q;
  assign pending      = pending_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_fastram_dram_scheduler.sv
// Directed bench for fastram_dram_scheduler: refresh timing, read/write access,
// refresh/CPU contention, debt saturation and asynchronous reset.
module tb_fastram_dram_scheduler;
  logic       CLK = 1'b0, RESETn = 1'b1;
  logic       req = 1'b0, rw_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1;
  logic [1:0] bank = 2'd0;
  logic [3:0] ras_n;
  logic       ucas_n, lcas_n, mem_we_n, col_sel, ack, refresh_busy, overrun;
  logic [2:0] pending;

  int checks = 0, failures = 0, ncyc = 0;
  bit mon_en = 0, rb_prev = 0, ov_seen = 0;
  int max_p = 0, rf_n = 0, rf_pend = -1;

  always #5 CLK = ~CLK;

  fastram_dram_scheduler dut (
    .CLK(CLK), .RESETn(RESETn), .req(req), .bank(bank), .rw_n(rw_n),
    .uds_n(uds_n), .lds_n(lds_n), .ras_n(ras_n), .ucas_n(ucas_n), .lcas_n(lcas_n),
    .mem_we_n(mem_we_n), .col_sel(col_sel), .ack(ack), .refresh_busy(refresh_busy),
    .pending(pending), .overrun(overrun)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK); #2; ncyc++;
  endtask

  task automatic do_reset();
    req = 1'b0;
    #1 RESETn = 1'b0;
    @(posedge CLK); #2;
    RESETn = 1'b1;
    ncyc = 0;
  endtask

  task automatic wait_rb(input string tag, input int bound);
    int n = 0;
    while (!refresh_busy && n < bound) begin cyc(); n++; end
    chk(tag, refresh_busy, 1);
  endtask

  always @(negedge CLK) if (mon_en) begin
    if (int'(pending) > max_p) max_p = int'(pending);
    if (overrun) ov_seen = 1;
    if (refresh_busy && !rb_prev) begin
      rf_n++;
      if (rf_pend < 0) rf_pend = int'(pending);
    end
    rb_prev = refresh_busy;
  end

  initial begin
    // Reset values (async assertion)
    #1 RESETn = 1'b0;
    #1;
    chk("rst_ras", ras_n, 4'hF);   chk("rst_ucas", ucas_n, 1);  chk("rst_lcas", lcas_n, 1);
    chk("rst_we", mem_we_n, 1);    chk("rst_col", col_sel, 0);  chk("rst_ack", ack, 0);
    chk("rst_rb", refresh_busy, 0); chk("rst_pend", pending, 0); chk("rst_ov", overrun, 0);
    @(posedge CLK); #2; RESETn = 1'b1; ncyc = 0;

    // Idle refresh: first tick on edge 108, refresh sequence follows
    repeat (107) cyc();
    chk("t1_pend107", pending, 0);
    cyc(); chk("t1_pend108", pending, 1); chk("t1_rb108", refresh_busy, 0);
    cyc(); chk("t1_rfcas_rb", refresh_busy, 1); chk("t1_rfcas_ucas", ucas_n, 0);
           chk("t1_rfcas_lcas", lcas_n, 0); chk("t1_rfcas_ras", ras_n, 4'hF);
    cyc(); chk("t1_rfras1", ras_n, 4'h0); chk("t1_pend_dec", pending, 0); chk("t1_cas_held", ucas_n, 0);
    cyc(); chk("t1_rfras2", ras_n, 4'h0);
    cyc(); chk("t1_pre_ras", ras_n, 4'hF); chk("t1_pre_rb", refresh_busy, 0); chk("t1_pre_ucas", ucas_n, 1);
    cyc();

    // Read, bank 2, upper byte only, req held 6 edges
    req = 1; bank = 2'd2; rw_n = 1; uds_n = 0; lds_n = 1;
    cyc(); chk("t2_row_ras", ras_n, 4'b1011); chk("t2_row_col", col_sel, 0); chk("t2_row_ack", ack, 0);
    cyc(); chk("t2_col_col", col_sel, 1); chk("t2_col_ack", ack, 0); chk("t2_col_ucas", ucas_n, 1);
    cyc(); chk("t2_cas_ack", ack, 1); chk("t2_cas_ucas", ucas_n, 0); chk("t2_cas_lcas", lcas_n, 1);
           chk("t2_cas_we", mem_we_n, 1); chk("t2_cas_ras", ras_n, 4'b1011);
    repeat (3) cyc();
    chk("t2_hold_ack", ack, 1); chk("t2_hold_lcas", lcas_n, 1);
    req = 0;
    cyc(); chk("t2_pre_ras", ras_n, 4'hF); chk("t2_pre_ack", ack, 0);
           chk("t2_pre_col", col_sel, 0); chk("t2_pre_ucas", ucas_n, 1);
    cyc();

    // Write, bank 0, both bytes
    req = 1; bank = 2'd0; rw_n = 0; uds_n = 0; lds_n = 0;
    cyc(); chk("t3_row_ras", ras_n, 4'b1110); chk("t3_row_we", mem_we_n, 0);
    cyc(); chk("t3_col_we", mem_we_n, 0);
    cyc(); chk("t3_cas_ack", ack, 1); chk("t3_cas_we", mem_we_n, 0);
           chk("t3_cas_ucas", ucas_n, 0); chk("t3_cas_lcas", lcas_n, 0);
    req = 0; rw_n = 1;
    cyc(); chk("t3_pre_we", mem_we_n, 1); chk("t3_pre_ras", ras_n, 4'hF);
    cyc();

    // Next refresh: we stays high; req raised in first RF_CAS cycle waits 4 extra cycles
    wait_rb("t5_rf_wait", 120);
    chk("t5_rf_we", mem_we_n, 1); chk("t5_rf_ras", ras_n, 4'hF); chk("t5_rf_ucas", ucas_n, 0);
    req = 1; bank = 2'd1; uds_n = 1; lds_n = 0;
    cyc(); chk("t5_rfras1", ras_n, 4'h0); chk("t5_rfras1_rb", refresh_busy, 1);
    cyc(); chk("t5_rfras2", ras_n, 4'h0);
    cyc(); chk("t5_pre_ras", ras_n, 4'hF); chk("t5_pre_rb", refresh_busy, 0);
    cyc(); chk("t5_idle_ras", ras_n, 4'hF); chk("t5_idle_ack", ack, 0);
    cyc(); chk("t5_row_ras", ras_n, 4'b1101);
    cyc(); chk("t5_col_ack", ack, 0);
    cyc(); chk("t5_ack_lat7", ack, 1); chk("t5_ucas", ucas_n, 1); chk("t5_lcas", lcas_n, 0);
    req = 0;
    cyc(); cyc();

    // Aborted access: req drops during ACC_COL
    req = 1; bank = 2'd3; uds_n = 0; lds_n = 0;
    cyc(); chk("t6_row_ras", ras_n, 4'b0111);
    cyc(); chk("t6_col_ack", ack, 0); chk("t6_col_ucas", ucas_n, 1);
    req = 0;
    cyc(); chk("t6_pre_ras", ras_n, 4'hF); chk("t6_pre_ack", ack, 0);
           chk("t6_pre_ucas", ucas_n, 1); chk("t6_pre_lcas", lcas_n, 1); chk("t6_pre_col", col_sel, 0);
    cyc();

    // Back-to-back accesses for 5 intervals: refresh only when debt hits 4
    do_reset();
    mon_en = 1; bank = 2'd1; rw_n = 1;
    while (ncyc < 560) begin
      int n;
      req = 1; n = 0;
      while (!ack && n < 30) begin cyc(); n++; end
      chk("t4_ack", ack, 1);
      cyc();
      req = 0;
      cyc();
    end
    mon_en = 0; req = 0;
    chk("t4_max_pend", max_p, 4);
    chk("t4_rf_at4", rf_pend, 4);
    chk("t4_rf_count", rf_n, 2);
    chk("t4_overrun", ov_seen, 0);

    // Access held forever: debt saturates at 7, next tick sets overrun
    do_reset();
    req = 1; bank = 2'd0;
    while (ncyc < 755) cyc();
    chk("t7_pend6", pending, 6); chk("t7_ack", ack, 1);
    while (ncyc < 760) cyc();
    chk("t7_pend7", pending, 7); chk("t7_ov0", overrun, 0);
    while (ncyc < 870) cyc();
    chk("t7_pend_sat", pending, 7); chk("t7_ov1", overrun, 1);
    req = 0;
    wait_rb("t7_rf_wait", 10);
    chk("t7_rf_pend", pending, 7);
    cyc(); chk("t7_rfras", ras_n, 4'h0); chk("t7_rf_dec", pending, 6);

    // Async reset in the middle of RF_RAS
    #1 RESETn = 1'b0;
    #1;
    chk("t8_ras", ras_n, 4'hF); chk("t8_ucas", ucas_n, 1); chk("t8_lcas", lcas_n, 1);
    chk("t8_rb", refresh_busy, 0); chk("t8_pend", pending, 0); chk("t8_ov", overrun, 0);
    chk("t8_we", mem_we_n, 1); chk("t8_ack", ack, 0); chk("t8_col", col_sel, 0);
    @(posedge CLK); #2; RESETn = 1'b1;
    cyc();
    chk("t8_post_ras", ras_n, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
